det3x3_seq: RTL and testbench

DET3X3_SEQ -- requirements
Module: det3x3_seq

---
 rtl/det3x3_seq_pkg.sv | 23 ++
 rtl/det3x3_seq_q_mul_sat.sv | 49 ++++
 rtl/det3x3_seq.sv | 159 +++++++++++++++
 tb/tb_det3x3_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/det3x3_seq_pkg.sv
// Shared types and constants for the sequential 3x3 fixed-point determinant unit.
package det3x3_seq_pkg;

  localparam int unsigned DET_WIDTH     = 64;
  localparam int unsigned DET_FRAC_BITS = 32;

  localparam logic signed [DET_WIDTH-1:0] MAX_Q = {1'b0, {(DET_WIDTH-1){1'b1}}};
  localparam logic signed [DET_WIDTH-1:0] MIN_Q = {1'b1, {(DET_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // How a step's rounded product combines with the running partial value
  typedef enum logic [1:0] {
    ACC_LOAD = 2'd0,
    ACC_SUB  = 2'd1,
    ACC_ADD  = 2'd2
  } acc_op_t;

endpackage

// File: rtl/det3x3_seq_q_mul_sat.sv
// Combinational fixed-point multiply: full-precision product, round half toward +inf,
// then saturate to the signed word range with an overflow flag.
module q_mul_sat
  import det3x3_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DET_WIDTH,
  parameter int unsigned FRAC_BITS = DET_FRAC_BITS
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p_c,
  output logic                    o_ovf_c
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] L_MAX =
    (WIDTH == DET_WIDTH) ? WIDTH'(MAX_Q) : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] L_MIN =
    (WIDTH == DET_WIDTH) ? WIDTH'(MIN_Q) : {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic signed [PW-1:0] RND_HALF = PW'(1) << (FRAC_BITS - 1);

  logic signed [PW-1:0] w_a_x;
  logic signed [PW-1:0] w_b_x;
  logic signed [PW-1:0] w_full;
  logic signed [PW-1:0] w_rnd;
  logic signed [PW-1:0] w_shr;

  // Product cannot overflow PW bits, and adding half an LSB stays in range too
  always_comb begin
    w_a_x  = PW'(i_a);
    w_b_x  = PW'(i_b);
    w_full = w_a_x * w_b_x;
    w_rnd  = w_full + RND_HALF;
    w_shr  = w_rnd >>> FRAC_BITS;

    o_p_c   = w_shr[WIDTH-1:0];
    o_ovf_c = 1'b0;
    if (w_shr > PW'(L_MAX)) begin
      o_p_c   = L_MAX;
      o_ovf_c = 1'b1;
    end else if (w_shr < PW'(L_MIN)) begin
      o_p_c   = L_MIN;
      o_ovf_c = 1'b1;
    end
  end

endmodule

// File: rtl/det3x3_seq.sv
// Sequential 3x3 determinant by cofactor expansion along the first row,
// one shared saturating fixed-point multiplier, nine product steps per job.
module det3x3_seq
  import det3x3_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DET_WIDTH,
  parameter int unsigned FRAC_BITS = DET_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [9*WIDTH-1:0]      m,
  output logic signed [WIDTH-1:0] det,
  output logic                    done,
  output logic                    busy,
  output logic                    singular,
  output logic                    ovf
);

  localparam logic signed [WIDTH-1:0] L_MAX =
    (WIDTH == DET_WIDTH) ? WIDTH'(MAX_Q) : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] L_MIN =
    (WIDTH == DET_WIDTH) ? WIDTH'(MIN_Q) : {1'b1, {(WIDTH-1){1'b0}}};

  // Element indices, row-major a..i
  localparam int unsigned EA = 0, EB = 1, EC = 2, ED = 3, EE = 4,
                          EF = 5, EG = 6, EH = 7, EI = 8;

  state_t                  r_state;
  logic [3:0]              r_k;
  logic signed [WIDTH-1:0] r_m [9];
  logic signed [WIDTH-1:0] r_t;
  logic signed [WIDTH-1:0] r_m0;
  logic signed [WIDTH-1:0] r_m1;
  logic signed [WIDTH-1:0] r_m2;
  logic signed [WIDTH-1:0] r_acc;

  logic signed [WIDTH-1:0] w_x;
  logic signed [WIDTH-1:0] w_y;
  logic signed [WIDTH-1:0] w_base;
  acc_op_t                 w_op;
  logic signed [WIDTH-1:0] w_p;
  logic                    w_p_ovf;
  logic signed [WIDTH:0]   w_base_x;
  logic signed [WIDTH:0]   w_p_x;
  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH-1:0] w_res;
  logic                    w_sum_ovf;
  logic                    w_step_ovf;

  q_mul_sat #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .i_a     (w_x),
    .i_b     (w_y),
    .o_p_c   (w_p),
    .o_ovf_c (w_p_ovf)
  );

  // Operand and combine-op selection for the current step
  always_comb begin
    w_x    = r_m[EA];
    w_y    = r_m[EA];
    w_base = r_t;
    w_op   = ACC_LOAD;
    case (r_k)
      4'd0: begin w_x = r_m[EE]; w_y = r_m[EI]; end
      4'd1: begin w_x = r_m[EF]; w_y = r_m[EH]; w_op = ACC_SUB; end
      4'd2: begin w_x = r_m[ED]; w_y = r_m[EI]; end
      4'd3: begin w_x = r_m[EF]; w_y = r_m[EG]; w_op = ACC_SUB; end
      4'd4: begin w_x = r_m[ED]; w_y = r_m[EH]; end
      4'd5: begin w_x = r_m[EE]; w_y = r_m[EG]; w_op = ACC_SUB; end
      4'd6: begin w_x = r_m[EA]; w_y = r_m0; end
      4'd7: begin w_x = r_m[EB]; w_y = r_m1; w_base = r_acc; w_op = ACC_SUB; end
      4'd8: begin w_x = r_m[EC]; w_y = r_m2; w_base = r_acc; w_op = ACC_ADD; end
      default: ;
    endcase
  end

  // Saturating add/subtract of the product into the partial value
  always_comb begin
    w_base_x  = (WIDTH+1)'(w_base);
    w_p_x     = (WIDTH+1)'(w_p);
    w_sum     = (w_op == ACC_ADD) ? (w_base_x + w_p_x) : (w_base_x - w_p_x);
    w_res     = w_sum[WIDTH-1:0];
    w_sum_ovf = 1'b0;
    if (w_op == ACC_LOAD) begin
      w_res = w_p;
    end else if (w_sum > (WIDTH+1)'(L_MAX)) begin
      w_res     = L_MAX;
      w_sum_ovf = 1'b1;
    end else if (w_sum < (WIDTH+1)'(L_MIN)) begin
      w_res     = L_MIN;
      w_sum_ovf = 1'b1;
    end
    w_step_ovf = w_p_ovf | w_sum_ovf;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_k      <= 4'd0;
      r_t      <= '0;
      r_m0     <= '0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_acc    <= '0;
      det      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      singular <= 1'b0;
      ovf      <= 1'b0;
      for (int n = 0; n < 9; n++) begin
        r_m[n] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            for (int n = 0; n < 9; n++) begin
              r_m[n] <= m[n*WIDTH +: WIDTH];
            end
            r_k     <= 4'd0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          ovf <= ovf | w_step_ovf;
          case (r_k)
            4'd0, 4'd2, 4'd4: r_t   <= w_res;
            4'd1:             r_m0  <= w_res;
            4'd3:             r_m1  <= w_res;
            4'd5:             r_m2  <= w_res;
            default:          r_acc <= w_res;
          endcase
          if (r_k == 4'd8) begin
            r_state <= FIN;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        FIN: begin
          det      <= r_acc;
          singular <= (r_acc == '0);
          done     <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det3x3_seq.sv
// Directed self-checking bench for det3x3_seq: vector table plus hand-written
// sequences for mid-job start, mid-job reset and back-to-back jobs.
module tb_det3x3_seq;

  localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
  localparam logic [63:0] QMAX  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] QMIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] BIG   = 64'h0001_0000_0000_0000;
  localparam logic [63:0] NBIG  = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] HALF  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LSB   = 64'h0000_0000_0000_0001;
  localparam logic [63:0] NLSB  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] GARB  = 64'h5A5A_A5A5_1234_5678;
  localparam int          NVEC  = 10;

  typedef struct packed {
    logic [575:0] m;
    logic [63:0]  det;
    logic         sing;
    logic         ovf;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [575:0]       m;
  logic signed [63:0] det;
  logic               done;
  logic               busy;
  logic               singular;
  logic               ovf;

  int n_tests;
  int n_fail;
  vec_t vecs [NVEC];

  det3x3_seq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .m        (m),
    .det      (det),
    .done     (done),
    .busy     (busy),
    .singular (singular),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [575:0] mk(input logic [63:0] a, b, c, d, e, f, g, h, i);
    return {i, h, g, f, e, d, c, b, a};
  endfunction

  function automatic logic [63:0] fx(input int v);
    logic signed [63:0] r;
    r = 64'(v);
    return r <<< 32;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accept one job, scramble m afterwards, check latency and all outputs
  task automatic run_job(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    m     = v.m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m     = {9{GARB}};
    check({tag, ".busy_after_accept"}, 64'(busy), 64'd1);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    check({tag, ".latency"}, 64'(lat), 64'd10);
    check({tag, ".det"}, det, v.det);
    check({tag, ".singular"}, 64'(singular), 64'(v.sing));
    check({tag, ".ovf"}, 64'(ovf), 64'(v.ovf));
    check({tag, ".busy_in_done"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
    check({tag, ".busy_cleared"}, 64'(busy), 64'd0);
    check({tag, ".det_held"}, det, v.det);
  endtask

  initial begin
    int lat;
    int cnt;
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    m       = '0;

    vecs[0] = '{m: mk(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE), det: ONE, sing: 1'b0, ovf: 1'b0};
    vecs[1] = '{m: mk(fx(2), 0, 0, 0, fx(3), 0, 0, 0, fx(-4)),
                det: 64'hFFFF_FFE8_0000_0000, sing: 1'b0, ovf: 1'b0};
    vecs[2] = '{m: mk(fx(1), fx(2), fx(3), fx(2), fx(4), fx(6), fx(7), fx(8), fx(9)),
                det: 64'd0, sing: 1'b1, ovf: 1'b0};
    vecs[3] = '{m: mk(QMAX, QMAX, QMAX, QMAX, QMAX, QMAX, QMAX, QMAX, QMAX),
                det: 64'd0, sing: 1'b1, ovf: 1'b1};
    vecs[4] = '{m: mk(HALF, 0, 0, 0, HALF, 0, 0, 0, HALF),
                det: 64'h0000_0000_2000_0000, sing: 1'b0, ovf: 1'b0};
    vecs[5] = '{m: mk(fx(2), fx(-1), 0, fx(1), fx(3), fx(2), 0, fx(1), fx(4)),
                det: fx(24), sing: 1'b0, ovf: 1'b0};
    vecs[6] = '{m: mk(BIG, 0, 0, 0, BIG, 0, 0, 0, BIG), det: QMAX, sing: 1'b0, ovf: 1'b1};
    vecs[7] = '{m: mk(NBIG, 0, 0, 0, BIG, 0, 0, 0, BIG), det: QMIN, sing: 1'b0, ovf: 1'b1};
    vecs[8] = '{m: mk(ONE, 0, 0, 0, LSB, 0, 0, 0, HALF), det: LSB, sing: 1'b0, ovf: 1'b0};
    vecs[9] = '{m: mk(ONE, 0, 0, 0, NLSB, 0, 0, 0, HALF), det: 64'd0, sing: 1'b1, ovf: 1'b0};

    #1;
    check("reset.det", det, 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.singular", 64'(singular), 64'd0);
    check("reset.ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      run_job($sformatf("vec%0d", v), vecs[v]);
    end

    // Start re-pulsed mid-job with a different matrix must be ignored
    @(negedge clk);
    m     = vecs[0].m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin
        m     = vecs[1].m;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) lat = c;
    end
    check("midstart.latency", 64'(lat), 64'd10);
    check("midstart.det", det, ONE);
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("midstart.no_second_job", 64'(cnt), 64'd0);

    // Reset asserted at k=5 of a job that has already flagged overflow
    @(negedge clk);
    m     = vecs[6].m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midreset.pre_ovf", 64'(ovf), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset.det", det, 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.singular", 64'(singular), 64'd0);
    check("midreset.ovf", 64'(ovf), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt   = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("midreset.quiet", 64'(cnt), 64'd0);
    run_job("after_reset", vecs[5]);

    // Start held high: second job accepted on the edge ending the done cycle
    @(negedge clk);
    m     = vecs[0].m;
    start = 1'b1;
    @(posedge clk); #1;
    m   = vecs[1].m;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    check("b2b.first_latency", 64'(lat), 64'd10);
    check("b2b.first_det", det, ONE);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (done) lat = c;
    end
    check("b2b.period", 64'(lat), 64'd11);
    check("b2b.second_det", det, vecs[1].det);
    @(posedge clk); #1;
    check("b2b.idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
